pulse_stretcher_mc: RTL and testbench

- Multi-channel, run-time programmable pulse stretcher. Generalises the single fixed-length expander used on PS2 and keyboard strobes.
- Each channel turns a trigger into an output pulse of exactly LEN clock cycles. LEN is per-channel and register-programmable.
- Each channel runs in one of two modes: one-shot (non-retriggerable) or retriggerable.
- Sits between the PS2 and GPIO event sources and the LED/interrupt logic. Emits a one-cycle done strobe at the end of every pulse.

---
 rtl/pulse_stretcher_mc.sv | 57 +++++
 tb/tb_pulse_stretcher_mc.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pulse_stretcher_mc.sv
// pulse_stretcher_mc: multi-channel programmable pulse stretcher, one-shot or retriggerable per channel.
// Define PULSE_STRETCH_EDGE_EN to trigger on rising edges of pulse_in instead of its level.
module pulse_stretcher_mc #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 25,
  parameter int SEL_W       = 2,
  parameter int DEFAULT_LEN = 5000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] pulse_in,
  input  logic [CHANNELS-1:0] mode,
  input  logic                len_we,
  input  logic [SEL_W-1:0]    len_sel,
  input  logic [CNT_W-1:0]    len_data,
  output logic [CHANNELS-1:0] pulse_out,
  output logic [CHANNELS-1:0] done,
  output logic                busy
);
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CNT_W-1:0]    len_q [CHANNELS];
  logic [CNT_W-1:0]    len_d [CHANNELS];
  logic [CHANNELS-1:0] trig, pulse_out_d, pulse_out_q, done_d, done_q;
  logic                busy_d, busy_q;
`ifdef PULSE_STRETCH_EDGE_EN
  logic [CHANNELS-1:0] prev_q, prev_d;
  assign prev_d = pulse_in;
  assign trig   = pulse_in & ~prev_q;
  always_ff @(posedge clk) prev_q <= reset ? '0 : prev_d;
`else
  assign trig = pulse_in;
`endif
  // Loads read the registered length, so a same-cycle write only affects later loads.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = (trig[i] && len_q[i] != '0 && (cnt_q[i] == '0 || mode[i])) ? len_q[i] :
                 (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : '0;
      len_d[i] = (len_we && int'(len_sel) == i) ? len_data : len_q[i];
      pulse_out_d[i] = cnt_d[i] != '0;
      done_d[i] = cnt_q[i] != '0 && cnt_d[i] == '0;
    end
  end
  assign busy_d = |pulse_out_d;
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_q[i] <= reset ? '0 : cnt_d[i];
      len_q[i] <= reset ? CNT_W'(DEFAULT_LEN) : len_d[i];
    end
    pulse_out_q <= reset ? '0 : pulse_out_d;
    done_q      <= reset ? '0 : done_d;
    busy_q      <= reset ? 1'b0 : busy_d;
  end
  assign pulse_out = pulse_out_q;
  assign done      = done_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_pulse_stretcher_mc.sv
// tb_pulse_stretcher_mc: directed checks of pulse_stretcher_mc with hand-computed expectations.
module tb_pulse_stretcher_mc;
  logic        clk = 0;
  logic        reset = 1;
  logic [3:0]  pulse_in = '0;
  logic [3:0]  mode = '0;
  logic        len_we = 0;
  logic [1:0]  len_sel = '0;
  logic [24:0] len_data = '0;
  logic [3:0]  pulse_out, done;
  logic        busy;
  int checks = 0, errors = 0;
  int hi, dn;
  pulse_stretcher_mc dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .mode(mode), .len_we(len_we),
    .len_sel(len_sel), .len_data(len_data), .pulse_out(pulse_out), .done(done), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [1:0] sel, input logic [24:0] data);
    len_we = 1; len_sel = sel; len_data = data;
    step();
    len_we = 0;
  endtask
  // Drives mask for the first step (or all steps if hold) and counts pulse_out/done highs on channel ch.
  task automatic run(input int ch, input logic [3:0] mask, input int n, input bit hold,
                     output int h, output int d);
    h = 0; d = 0;
    pulse_in = mask;
    for (int k = 0; k < n; k++) begin
      step();
      if (!hold) pulse_in = '0;
      h += int'(pulse_out[ch]);
      d += int'(done[ch]);
    end
    pulse_in = '0;
  endtask
  initial begin
    step(); step();
    reset = 0;
    chk("rst_pulse_out", pulse_out, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    run(0, 4'b0001, 5000, 0, hi, dn);
    chk("t1_highs", hi, 5000);
    chk("t1_no_early_done", dn, 0);
    chk("t1_busy_high", busy, 1);
    chk("t1_others_idle", pulse_out[3:1], 0);
    step();
    chk("t1_end_pulse", pulse_out[0], 0);
    chk("t1_done", done[0], 1);
    chk("t1_busy_low", busy, 0);
    step();
    chk("t1_done_one_cycle", done[0], 0);
    wr(2'd1, 25'd3);
    pulse_in = 4'b0010; step(); pulse_in = '0;
    chk("t2_rise", pulse_out[1], 1);
    step();
    pulse_in = 4'b0010; step(); pulse_in = '0;
    chk("t2_oneshot_t3", pulse_out[1], 1);
    step();
    chk("t2_end", pulse_out[1], 0);
    chk("t2_done", done[1], 1);
    run(1, 4'b0010, 4, 0, hi, dn);
    chk("t2_second_highs", hi, 3);
    chk("t2_second_done", dn, 1);
    mode = 4'b0100;
    wr(2'd2, 25'd4);
    pulse_in = 4'b0100; step(); pulse_in = '0;
    chk("t3_rise", pulse_out[2], 1);
    step(); step();
    chk("t3_still_high", pulse_out[2], 1);
    run(2, 4'b0100, 4, 0, hi, dn);
    chk("t3_retrig_highs", hi, 4);
    chk("t3_no_mid_done", dn, 0);
    step();
    chk("t3_end", pulse_out[2], 0);
    chk("t3_done", done[2], 1);
    mode = '0;
    wr(2'd3, 25'd10);
    pulse_in = 4'b1000; step(); pulse_in = '0;
    chk("t4_rise", pulse_out[3], 1);
    wr(2'd3, 25'd2);
    chk("t4_after_write", pulse_out[3], 1);
    run(3, 4'b0000, 12, 0, hi, dn);
    chk("t4_old_len_highs", hi, 8);
    chk("t4_old_len_done", dn, 1);
    run(3, 4'b1000, 4, 0, hi, dn);
    chk("t4_new_len_highs", hi, 2);
    chk("t4_new_len_done", dn, 1);
    wr(2'd3, 25'd0);
    run(3, 4'b1000, 4, 0, hi, dn);
    chk("t4_disabled_highs", hi, 0);
    chk("t4_disabled_done", dn, 0);
    wr(2'd0, 25'd8);
    pulse_in = 4'b0001; step(); pulse_in = '0;
    step(); step(); step();
    chk("t5_mid_pulse", pulse_out[0], 1);
    reset = 1; step(); reset = 0;
    chk("t5_rst_pulse_out", pulse_out, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_busy", busy, 0);
    step();
    chk("t5_no_done", done, 0);
    run(0, 4'b0001, 5001, 0, hi, dn);
    chk("t5_len_restored", hi, 5000);
    chk("t5_len_restored_done", dn, 1);
    mode = 4'b0001;
    wr(2'd0, 25'd3);
    run(0, 4'b0001, 20, 1, hi, dn);
`ifdef PULSE_STRETCH_EDGE_EN
    chk("t6_edge_highs", hi, 3);
    chk("t6_edge_done", dn, 1);
    run(0, 4'b0000, 6, 0, hi, dn);
    chk("t6_edge_tail_highs", hi, 0);
    chk("t6_edge_tail_done", dn, 0);
`else
    chk("t6_level_highs", hi, 20);
    chk("t6_level_done", dn, 0);
    run(0, 4'b0000, 6, 0, hi, dn);
    chk("t6_level_tail_highs", hi, 2);
    chk("t6_level_tail_done", dn, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
